pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumer-side controller for the PLL clocking interface; runs on the free-running board reference clock.
- Drives the PLL's active-high `rst` and watches its asynchronous `locked` output.
- Holds the core reset until lock has been stable for a programmable time.
- On timeout it retries with a bounded count; on lock loss in operation it re-resets the core and the PLL. Exports status for debug.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per reset attempt (>=1).
- LOCK_TIMEOUT, 50000: refclk cycles to wait for lock after each pulse before retrying (>=1).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before core reset release (>=1).
- MAX_RETRIES, 7: retry attempts allowed after the initial attempt before declaring failure.
- LOSS_CNT_W, 8: width of the lock-loss event counter.
- LOSS_FILTER, 4: cycles of continuous low lock needed to count as loss; used only with the optional feature.

Ports:
- refclk, in, 1: 50 MHz board clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-low reset.
- pll_locked, in, 1: PLL `locked`; asynchronous to refclk.
- pll_rst, out, 1: to PLL `rst`; active high.
- sys_rst_n, out, 1: core reset for the PLL output domains; active low; consumers re-synchronize it.
- ready, out, 1: high while in RUN.
- fail, out, 1: high in FAIL; terminal state.
- retry_count, out, 4: retries used in the current acquisition.
- loss_count, out, LOSS_CNT_W: saturating count of lock-loss events since reset.

Behaviour:
- Synchronizer: `pll_locked` passes through a 2-FF synchronizer; its output is `lock_s`. Both FFs clear to 0 on reset.
- Reset (`rst`=0 at an edge):
  - state=PULSE, all counters 0, both sync FFs 0.
  - Outputs: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `retry_count`=0, `loss_count`=0.
  - Mid-operation reset aborts any state on the same edge.
- Outputs are registered Moore decodes of state:
  - `pll_rst`=1 in PULSE and FAIL.
  - `sys_rst_n`=1 and `ready`=1 only in RUN.
  - `fail`=1 only in FAIL.
- PULSE: cycle counter starts at 0 on entry. At the edge where counter==RST_PULSE_CYCLES-1, go to WAIT_LOCK. `pll_rst` is therefore high exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: timer starts at 0 on entry.
  - `lock_s`=1 → go to STABLE with count=0. Lock wins over a timeout on the same edge.
  - Else, at timer==LOCK_TIMEOUT-1:
    - if `retry_count`==MAX_RETRIES → go to FAIL;
    - else `retry_count`+1 and go to PULSE.
  - Else timer+1.
- STABLE: `lock_s`=0 → back to WAIT_LOCK, timer restarts at 0. Otherwise:
  - at count==STABLE_CYCLES-1 → go to RUN;
  - else count+1.
- Lock latency: with `pll_locked` held high from the edge that first samples it (edge 1), `ready`/`sys_rst_n` rise at edge STABLE_CYCLES+3.
- RUN: a lock-loss event (`lock_s`=0, or filtered, see below) causes, on that edge:
  - go to PULSE;
  - `retry_count`←0;
  - `loss_count`+1, saturating at all-ones.
  - `sys_rst_n`/`ready` drop on that edge, i.e. 3 edges after `pll_locked` falls.
- FAIL: stays until `rst`. Holds `pll_rst`=1, `sys_rst_n`=0, and `retry_count` frozen at MAX_RETRIES.
- Total attempts before FAIL = MAX_RETRIES+1.
- Counter widths: `clog2` of each parameter. No wrap-around is possible given the compare-before-increment rules above.

Optional Feature:
- Macro: PLL_SUP_LOSS_FILTER_EN.
- Defined:
  - In RUN, a filter counter clears while `lock_s`=1 and increments while `lock_s`=0.
  - Loss is declared at the edge where the counter reaches LOSS_FILTER-1 with `lock_s` still 0.
  - Lows shorter than LOSS_FILTER cycles are ignored and do not change `loss_count`.
  - STABLE is unfiltered.
- Undefined: any single `lock_s`=0 cycle in RUN is a loss. The LOSS_FILTER parameter is unused.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_CNT_W=4.
1. Clean bring-up: hold `rst`=0 for 3 cycles, then release. Raise `pll_locked` 5 cycles after `pll_rst` falls. → `pll_rst` high exactly 4 cycles after release; `ready`=`sys_rst_n`=1 at edge 11 after first sampled lock; `retry_count`=0.
2. Never locks: `pll_locked`=0 forever. → three 4-cycle `pll_rst` pulses each followed by 20-cycle waits. `fail`=1 and `pll_rst`=1 from cycle 72 after release; `retry_count`=2; `ready` never asserts.
3. Glitch in STABLE: after lock, drop `pll_locked` 1 cycle when the stable count is 5. → returns to WAIT_LOCK; `ready` is delayed by 8 full stable cycles from the relock; no `pll_rst` pulse occurs.
4. Lock loss in RUN, macro undefined: drop `pll_locked` for 1 cycle. → `sys_rst_n` low 3 edges later; `loss_count`=1; 4-cycle `pll_rst` pulse; re-acquisition to `ready` with `retry_count`=0.
5. Saturation: force 17 loss/relock cycles. → `loss_count` stops at 15.
6. Macro defined, LOSS_FILTER=4: a 2-cycle low in RUN → `ready` stays 1 and `loss_count` unchanged. A 6-cycle low → loss declared, `loss_count`+1.
7. Mid-operation reset: assert `rst` during WAIT_LOCK → next edge shows every output at its reset value.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Consumer-side PLL bring-up controller running on the free-running board
//   reference clock. Pulses the PLL reset, waits for a synchronized lock,
//   requires the lock to stay up for STABLE_CYCLES, then releases the core
//   reset. It retries a bounded number of times when lock does not arrive,
//   and re-resets the core and the PLL when lock is lost in operation.
//
// Optional feature macro: PLL_SUP_LOSS_FILTER_EN
//   When defined, a lock drop in RUN counts as a loss only after LOSS_FILTER
//   consecutive low lock_s cycles. When undefined, any single low cycle in
//   RUN is a loss and LOSS_FILTER is unused.
//
// Ports
//   refclk       in   board reference clock; all logic on its rising edge
//   rst          in   synchronous active-low reset
//   pll_locked   in   PLL lock indicator, asynchronous to refclk
//   pll_rst      out  PLL reset, active high
//   sys_rst_n    out  core reset for PLL output domains, active low
//   ready        out  high while in RUN
//   fail         out  high in the terminal FAIL state
//   retry_count  out  retries used in the current acquisition
//   loss_count   out  saturating count of lock-loss events since reset
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 50000,
  parameter int STABLE_CYCLES    = 1024,
  parameter int MAX_RETRIES      = 7,
  parameter int LOSS_CNT_W       = 8,
  parameter int LOSS_FILTER      = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic                  fail,
  output logic [3:0]            retry_count,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  // One phase counter is shared by PULSE, WAIT_LOCK and STABLE since only
  // one of them is active at a time; it is sized for the largest limit.
  localparam int MAX_PT  = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_PT > STABLE_CYCLES) ? MAX_PT : STABLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LAST   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PULSE,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  // Registered output bundle, always loaded with the decode of the state
  // being entered so the outputs change on the same edge as the state.
  typedef struct packed {
    logic pll_rst;
    logic sys_rst_n;
    logic ready;
    logic fail;
  } ctl_t;

  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c.pll_rst   = (s == S_PULSE) || (s == S_FAIL);
    c.sys_rst_n = (s == S_RUN);
    c.ready     = (s == S_RUN);
    c.fail      = (s == S_FAIL);
    return c;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  ctl_t             ctl;
  logic [1:0]       sync_pipe;
  logic             lock_s;
  logic             loss_evt;

  // 2-FF synchronizer for the asynchronous lock indicator.
  always_ff @(posedge refclk) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[0], pll_locked};
  end

  assign lock_s = sync_pipe[1];

`ifdef PLL_SUP_LOSS_FILTER_EN
  localparam int               FILT_W    = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOSS_FILTER - 1);

  logic [FILT_W-1:0] filt;

  // Counts consecutive low lock_s cycles in RUN. It is cleared outside RUN
  // so every entry into RUN starts a fresh window; on the loss edge it
  // holds, and the following PULSE clears it.
  always_ff @(posedge refclk) begin
    if (!rst || (state != S_RUN) || lock_s) filt <= '0;
    else if (!loss_evt)                     filt <= filt + 1'b1;
  end

  assign loss_evt = (state == S_RUN) && !lock_s && (filt == FILT_LAST);
`else
  assign loss_evt = (state == S_RUN) && !lock_s;
`endif

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state       <= S_PULSE;
      cnt         <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      ctl         <= ctl_of(S_PULSE);
    end else begin
      case (state)
        S_PULSE: begin
          if (cnt == PULSE_LAST) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
            ctl   <= ctl_of(S_WAIT_LOCK);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // Lock takes priority over a timeout on the same edge.
          if (lock_s) begin
            state <= S_STABLE;
            cnt   <= '0;
            ctl   <= ctl_of(S_STABLE);
          end else if (cnt == TIMEOUT_LAST) begin
            cnt <= '0;
            if (retry_count == RETRY_LAST) begin
              state <= S_FAIL;
              ctl   <= ctl_of(S_FAIL);
            end else begin
              state       <= S_PULSE;
              retry_count <= retry_count + 4'd1;
              ctl         <= ctl_of(S_PULSE);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STABLE: begin
          // Any drop restarts the lock wait without pulsing the PLL.
          if (!lock_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
            ctl   <= ctl_of(S_WAIT_LOCK);
          end else if (cnt == STABLE_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
            ctl   <= ctl_of(S_RUN);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (loss_evt) begin
            state       <= S_PULSE;
            cnt         <= '0;
            retry_count <= '0;
            ctl         <= ctl_of(S_PULSE);
            if (loss_count != '1) loss_count <= loss_count + 1'b1;
          end
        end

        S_FAIL: begin
          // Terminal until reset; everything holds.
          ctl <= ctl_of(S_FAIL);
        end

        default: begin
          state <= S_PULSE;
          cnt   <= '0;
          ctl   <= ctl_of(S_PULSE);
        end
      endcase
    end
  end

  assign pll_rst   = ctl.pll_rst;
  assign sys_rst_n = ctl.sys_rst_n;
  assign ready     = ctl.ready;
  assign fail      = ctl.fail;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor. Stimulus is issued one refclk edge at a
// time; a reference model built on phase-entry timestamps and a lock history
// predicts the outputs after each edge and pushes them into a scoreboard
// queue that a separate monitor drains on the falling edge.
module tb_pll_lock_supervisor;
  localparam int P  = 4;
  localparam int T  = 20;
  localparam int S  = 8;
  localparam int R  = 2;
  localparam int LW = 4;
  localparam int LF = 4;
  localparam int LOSS_MAX = (1 << LW) - 1;

  logic          refclk = 1'b0;
  logic          rst = 1'b0;
  logic          pll_locked = 1'b0;
  logic          pll_rst, sys_rst_n, ready, fail;
  logic [3:0]    retry_count;
  logic [LW-1:0] loss_count;

  always #10 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(P), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S),
    .MAX_RETRIES(R), .LOSS_CNT_W(LW), .LOSS_FILTER(LF)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_count(retry_count), .loss_count(loss_count)
  );

  typedef struct {
    logic          pr, sn, rd, fl;
    logic [3:0]    rc;
    logic [LW-1:0] lc;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: phase plus the edge at which it was entered.
  typedef enum {M_PULSE, M_WAIT, M_STABLE, M_RUN, M_FAIL} mph_t;
  mph_t ph = M_PULSE;
  int   t_entry = 0;
  int   last_high = 0;
  int   m_retry = 0;
  int   m_loss = 0;
  bit   lk_hist[$];

  task automatic enter(input mph_t p);
    ph = p;
    t_entry = cyc;
  endtask

  task automatic model_edge(input bit rv, input bit lk);
    bit   ls;
    bit   lost;
    exp_t e;
    if (!rv) begin
      enter(M_PULSE);
      m_retry = 0;
      m_loss  = 0;
      lk_hist = {1'b0, 1'b0};
    end else begin
      // The FSM sees the level sampled two edges earlier.
      ls = lk_hist[0];
      void'(lk_hist.pop_front());
      lk_hist.push_back(lk);
      case (ph)
        M_PULSE:  if (cyc - t_entry == P) enter(M_WAIT);
        M_WAIT: begin
          if (ls) enter(M_STABLE);
          else if (cyc - t_entry == T) begin
            if (m_retry == R) enter(M_FAIL);
            else begin
              m_retry++;
              enter(M_PULSE);
            end
          end
        end
        M_STABLE: begin
          if (!ls) enter(M_WAIT);
          else if (cyc - t_entry == S) begin
            enter(M_RUN);
            last_high = cyc;
          end
        end
        M_RUN: begin
`ifdef PLL_SUP_LOSS_FILTER_EN
          if (ls) last_high = cyc;
          lost = !ls && (cyc - last_high == LF);
`else
          lost = !ls;
`endif
          if (lost) begin
            enter(M_PULSE);
            m_retry = 0;
            if (m_loss < LOSS_MAX) m_loss++;
          end
        end
        default: ;
      endcase
    end
    e.pr  = (ph == M_PULSE) || (ph == M_FAIL);
    e.sn  = (ph == M_RUN);
    e.rd  = (ph == M_RUN);
    e.fl  = (ph == M_FAIL);
    e.rc  = 4'(m_retry);
    e.lc  = LW'(m_loss);
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic step(input bit rv, input bit lk);
    @(negedge refclk);
    rst = rv;
    pll_locked = lk;
    @(posedge refclk);
    cyc++;
    model_edge(rv, lk);
  endtask

  task automatic steps(input int n, input bit rv, input bit lk);
    for (int i = 0; i < n; i++) step(rv, lk);
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every edge presents a registered output set to compare.
  always @(negedge refclk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (pll_rst !== e.pr || sys_rst_n !== e.sn || ready !== e.rd ||
          fail !== e.fl || retry_count !== e.rc || loss_count !== e.lc) begin
        errors++;
        $display("FAIL outputs edge %0d actual pll_rst=%b sys_rst_n=%b ready=%b fail=%b retry=%0d loss=%0d required %b %b %b %b %0d %0d",
                 e.cyc, pll_rst, sys_rst_n, ready, fail, retry_count, loss_count,
                 e.pr, e.sn, e.rd, e.fl, e.rc, e.lc);
      end
    end
  end

  initial begin
    int fall_at, rdy_at, fail_at, n, len;
    bit lv;

    // 1. Clean bring-up.
    steps(3, 1'b0, 1'b0);
    fall_at = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0);
      #1;
      if (!pll_rst && fall_at == 0) fall_at = i;
    end
    check_int("pll_rst_release_edge", fall_at, P);
    rdy_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1);
      #1;
      if (ready && sys_rst_n && rdy_at == 0) rdy_at = i;
    end
    check_int("lock_to_ready_edges", rdy_at, S + 3);
    check_int("retry_after_bringup", int'(retry_count), 0);

    // 2. Never locks.
    steps(3, 1'b0, 1'b0);
    fail_at = 0;
    for (int i = 1; i <= 85; i++) begin
      step(1'b1, 1'b0);
      #1;
      if (fail && fail_at == 0) fail_at = i;
    end
    check_int("fail_edge", fail_at, (R + 1) * (P + T));
    check_int("retry_in_fail", int'(retry_count), R);

    // 3. Glitch while STABLE, then relock.
    steps(2, 1'b0, 1'b0);
    steps(8, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    steps(20, 1'b1, 1'b1);

    // 4. Single-cycle loss in RUN, then 2-cycle and 6-cycle lows.
    step(1'b1, 1'b0);
    steps(25, 1'b1, 1'b1);
    steps(2, 1'b1, 1'b0);
    steps(25, 1'b1, 1'b1);
    steps(6, 1'b1, 1'b0);
    steps(25, 1'b1, 1'b1);

    // 5. Loss counter saturation.
    steps(2, 1'b0, 1'b0);
    steps(25, 1'b1, 1'b1);
    for (int k = 0; k < 17; k++) begin
      steps(6, 1'b1, 1'b0);
      steps(25, 1'b1, 1'b1);
    end
    #1;
    check_int("loss_count_saturated", int'(loss_count), LOSS_MAX);

    // 7. Reset while waiting for lock.
    steps(2, 1'b0, 1'b0);
    steps(P + 6, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Randomized lock behaviour with occasional resets.
    n = 0;
    while (n < 2500) begin
      lv = 1'($urandom_range(0, 1));
      if (lv) len = $urandom_range(1, 40);
      else if ($urandom_range(0, 7) == 0) len = $urandom_range(10, 90);
      else len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 299) == 0) step(1'b0, lv);
        else step(1'b1, lv);
      end
      n += len;
    end

    @(negedge refclk);
    #1;
    check_int("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
